// File: rtl/keep_one_in_n_unzip.sv
// Receive-side 4:1 expander: one packed word of four 4-bit I/Q symbols in,
// four sc16 samples out, MSB symbol first.
module keep_one_in_n_unzip #(
  parameter int WIDTH     = 32,
  parameter bit ALIGN_MSB = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready
);

  localparam int NUM_SYM = 4;

  logic [WIDTH-1:0] word_reg;
  logic             last_reg;
  logic             hold_valid;
  logic [1:0]       idx;

  logic             last_sym;
  logic             accept;
  logic             out_xfer;
  logic [WIDTH-1:0] sample_exp [NUM_SYM];

  // Expand one 4-bit two's complement nibble to a 16-bit component.
  function automatic logic [15:0] expand_nib(input logic [3:0] nib);
    logic [15:0] res;
    if (ALIGN_MSB) begin
      res = {nib, 12'h000};
    end else begin
      res = {{12{nib[3]}}, nib};
    end
    return res;
  endfunction

  assign last_sym = (idx == 2'd3);
  assign out_xfer = hold_valid & o_tready;

  // A new word may land in the same cycle the final sample leaves.
  assign i_tready = ~hold_valid | (o_tready & last_sym);
  assign accept   = i_tvalid & i_tready;

  // Symbol gi lives in byte (3-gi): emission runs from the top byte down.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SYM; gi++) begin : g_sym
      logic [7:0] sym_byte;
      assign sym_byte       = word_reg[WIDTH-1-8*gi -: 8];
      assign sample_exp[gi] = {expand_nib(sym_byte[7:4]), expand_nib(sym_byte[3:0])};
    end
  endgenerate

  always_comb begin
    o_tdata = sample_exp[idx];
  end

  assign o_tvalid = hold_valid;
  assign o_tlast  = hold_valid & last_reg & last_sym;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_reg   <= '0;
      last_reg   <= 1'b0;
      hold_valid <= 1'b0;
      idx        <= 2'd0;
    end else if (accept) begin
      word_reg   <= i_tdata;
      last_reg   <= i_tlast;
      hold_valid <= 1'b1;
      idx        <= 2'd0;
    end else if (out_xfer) begin
      if (last_sym) begin
        hold_valid <= 1'b0;
        idx        <= 2'd0;
      end else begin
        idx <= idx + 2'd1;
      end
    end
  end

endmodule

// File: doc/keep_one_in_n_unzip.md
Name: keep_one_in_n_unzip

Overview:
Receive-side expander matching the 4:1 I/Q compressor in the QPSK RFNoC chain. It takes one 32-bit AXI-Stream word that packs four symbols, each as an 8-bit byte of 4-bit I and 4-bit Q. It emits four 32-bit sc16 samples (16-bit I, 16-bit Q) in order. It sits between the packed-symbol stream and downstream sc16 processing, such as the modulator or DUC, and restores the original sample rate (1 word in, 4 samples out).

Parameters:
WIDTH, 32, stream data width; only 32 is supported.
ALIGN_MSB, 1, expansion mode. 1: the 4-bit value goes in bits [15:12] of each 16-bit component, with low 12 bits zero. 0: the 4-bit value is sign-extended to 16 bits.

Ports:
clk  input  1  clock; all logic is rising-edge.
reset  input  1  asynchronous, active-low reset. Low means reset; deassertion is synchronous to clk externally.
i_tdata  input  32  packed word, four bytes of {I[3:0], Q[3:0]}, two's complement.
i_tlast  input  1  end of packet on the packed stream.
i_tvalid  input  1  input valid.
i_tready  output  1  input ready.
o_tdata  output  32  expanded sample {I[15:0], Q[15:0]}.
o_tlast  output  1  end of packet on the expanded stream.
o_tvalid  output  1  output valid.
o_tready  input  1  output ready.

Behaviour:
- State consists of:
  - word_reg[31:0] holding the accepted word.
  - last_reg, holding the captured i_tlast.
  - hold_valid, the holding-register-occupied flag.
  - idx[1:0], the symbol index, counting 0..3.
- Reset (reset low, asynchronous): hold_valid=0, idx=0, word_reg=0, last_reg=0. Outputs during and after reset: o_tvalid=0, o_tlast=0, o_tdata=0, i_tready=1 once reset is released.
- Input handshake:
  - i_tready = ~hold_valid | (o_tready & idx==3).
  - An accept is i_tvalid & i_tready. On accept: word_reg<=i_tdata, last_reg<=i_tlast, hold_valid<=1, idx<=0.
- Output:
  - o_tvalid = hold_valid.
  - o_tdata is derived combinationally from word_reg and idx.
  - Emission order is byte[31:24] for idx 0, byte[23:16] for idx 1, byte[15:8] for idx 2, byte[7:0] for idx 3.
  - Within a byte, bits [7:4] are I and bits [3:0] are Q.
- Expansion:
  - ALIGN_MSB=1: I16 = {nib, 12'h000}.
  - ALIGN_MSB=0: I16 = {{12{nib[3]}}, nib}.
  - Q16 is formed the same way. o_tdata = {I16, Q16}.
- o_tlast = hold_valid & last_reg & (idx==3). Only the 4th sample of a tlast word carries tlast.
- Output transfer (o_tvalid & o_tready):
  - If idx<3: idx<=idx+1.
  - If idx==3 with no simultaneous accept: hold_valid<=0, idx<=0.
  - If idx==3 with a simultaneous accept: the new word loads, hold_valid stays 1, idx<=0. This gives zero bubbles.
- Latency: a word accepted at cycle t produces its first sample with o_tvalid=1 at cycle t+1. Sustained throughput is 1 input word per 4 cycles and 1 output sample per cycle.
- Backpressure: with o_tready low, o_tdata, o_tlast and idx hold stable, and i_tready=0 while hold_valid=1. Output data never changes while o_tvalid=1 and o_tready=0.
- i_tvalid deasserted after the last sample: o_tvalid drops the cycle after the idx==3 transfer. There is no stale re-emission.
- Reset mid-word: the partially emitted word is discarded and no remaining samples are emitted. After reset release, the next accepted word starts at idx 0.
- No internal tlast counting. Packet boundaries follow the input 1:1, with output packets 4x the input word count.

Test Plan:
- ALIGN_MSB=1: single word 0xA1BDEF3E with tlast=1, o_tready=1 -> outputs 0xA0001000, 0xB000D000, 0xE000F000, 0x3000E000 on consecutive cycles starting 1 cycle after accept; o_tlast=1 only on 0x3000E000.
- ALIGN_MSB=0: word 0xA1BDEF3E -> 0xFFFA0001, 0xFFFBFFFD, 0xFFFEFFFF, 0x0003FFFE.
- Continuous input of 8 words, i_tvalid always 1, o_tready=1 -> 32 contiguous output samples with no bubble; i_tready pulses high only on idx==3 cycles.
- o_tready toggled randomly (roughly 50%) over 16 words -> output sequence identical to the unthrottled case; o_tdata/o_tlast stable while stalled; no words lost or duplicated.
- Packets of 3 words with tlast on word 3 -> o_tlast exactly once per 12 output samples, on the 12th.
- reset pulsed low after 2 samples of word 0x12345678, then word 0x9ABCDEF0 sent -> no further samples from the first word; next outputs begin with the expansion of 0x9A.
